key_debounce_2b: RTL and testbench
==================================

// Module: key_debounce_2b
// PURPOSE
//  Upstream conditioning stage for the 5-state control FSM (s0..s4, 4-bit control code out).
//  Takes two raw, asynchronous, bouncing key/switch lines and delivers a clean 2-bit state_inputs bus.
//  The bus is synchronised to clk and changes only after the raw vector has been stable for DB_CYCLES clocks.
//  The FSM's state_inputs port connects directly to this block's state_inputs output.
// PARAMETERS
//  SYNC_STAGES  2   flip-flop synchroniser depth per bit; minimum 2
//  DB_CYCLES    16  consecutive stable clocks required before commit; minimum 1
//  CNT_W        5   stability counter width; must satisfy 2**CNT_W >= DB_CYCLES
// PORTS
//  clk           in   1  state machine working clock, rising edge
//  reset         in   1  asynchronous, active-low reset
//  key_in        in   2  raw asynchronous key levels, bit1 = MSB of state_inputs
//  state_inputs  out  2  debounced, registered vector; feeds the control FSM
//  change_stb    out  1  only with DB_CHANGE_STROBE_EN; see CONFIGURATION
// BEHAVIOUR
//  Reset (reset=0, async) clears:
//   - synchroniser chain, cand (candidate vector), cnt, change_stb -> 0
//   - state_inputs -> 2'b00, the value that holds the FSM in s0
//   - FSM state -> S_IDLE
//  On reset release, operation starts at the first rising clk edge. Reset mid-debounce aborts the pending candidate, with no strobe.
//  Synchroniser: sync_q is key_in delayed by SYNC_STAGES clocks. The whole 2-bit vector is debounced as one unit.
//  FSM states: S_IDLE, S_WAIT, S_COMMIT. State is registered, with one always block per state register and one for next-state.
//  S_IDLE:
//   - sync_q == state_inputs -> stay.
//   - sync_q != state_inputs -> cand <= sync_q, cnt <= 0, go S_WAIT.
//  S_WAIT, sync_q == cand, cnt < DB_CYCLES-1 -> cnt <= cnt+1, stay.
//  S_WAIT, sync_q == cand, cnt == DB_CYCLES-1 -> state_inputs <= cand, go S_COMMIT.
//  S_WAIT, sync_q != cand, sync_q == state_inputs -> bounce back: cnt <= 0, go S_IDLE, output untouched.
//  S_WAIT, sync_q != cand, sync_q != state_inputs -> new candidate: cand <= sync_q, cnt <= 0, stay in S_WAIT.
//  S_COMMIT: lasts exactly 1 cycle, input ignored, unconditionally go S_IDLE.
//   - If the input has moved again, S_IDLE detects it on the following edge.
//  Latency: key_in stable from before edge 1 -> state_inputs updates on edge SYNC_STAGES+1+DB_CYCLES (defaults: edge 19).
//  Minimum spacing between two output changes is DB_CYCLES+2 clocks.
//  Both bits changing on different edges count as a new candidate, and the counter restarts.
//  state_inputs never glitches; it is written only on the S_WAIT -> S_COMMIT edge.
//  cnt never wraps: max value DB_CYCLES-1. Counter arithmetic is unsigned, CNT_W bits.
//  An unused FSM state encoding -> S_IDLE next cycle, with no output change.
// CONFIGURATION
//  Macro DB_CHANGE_STROBE_EN:
//   - defined -> adds output change_stb (1 bit, registered). It is high for exactly the one cycle spent in S_COMMIT, i.e. the first cycle the new state_inputs value is visible. Reset value 0.
//   - undefined -> the port and its logic are absent, and all other behaviour is identical.
// TESTING  (defaults SYNC_STAGES=2, DB_CYCLES=16)
//  1. Reset: reset=0 with key_in=2'b11 -> state_inputs=2'b00 (change_stb=0). It stays 00 until edge 19 after reset release.
//  2. Clean step: key_in 00->10, applied before edge 1 -> state_inputs=10 from edge 19; change_stb=1 on cycle 19 only.
//  3. Bounce: key_in toggles 00/01 every 3 clocks for 40 clocks, then holds 01 -> no output change during bouncing. state_inputs=01 exactly 19 edges after the final toggle.
//  4. Bounce-back: key_in 00->11 for 10 clocks, then back to 00 -> state_inputs stays 00 and change_stb never asserts.
//  5. Candidate switch: 00->01 held 8 clocks, then 10 held -> the 01 count is discarded. state_inputs=10 at 19 edges after the 10 step.
//  6. Reset mid-debounce: 00->11, reset pulsed low at edge 10 -> immediate clear to 00. Full 19-edge latency is counted again after release; build once with and once without DB_CHANGE_STROBE_EN.

Source files
------------

// File: rtl/key_debounce_2b_if.sv
// Interface bundling the key inputs and the debounced outputs of key_debounce_2b.
// Optional macro: DB_CHANGE_STROBE_EN adds the change_stb signal.
interface key_debounce_2b_if;
    logic [1:0] key_in;
    logic [1:0] state_inputs;
`ifdef DB_CHANGE_STROBE_EN
    logic       change_stb;

    modport master (output key_in, input  state_inputs, input  change_stb);
    modport slave  (input  key_in, output state_inputs, output change_stb);
`else
    modport master (output key_in, input  state_inputs);
    modport slave  (input  key_in, output state_inputs);
`endif
endinterface

// File: rtl/key_debounce_2b.sv
// key_debounce_2b: synchronises and debounces two raw key lines into a clean
// 2-bit state_inputs bus for the downstream control FSM.
// Optional macro: DB_CHANGE_STROBE_EN adds a one-cycle change_stb output.
module key_debounce_2b #(
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 16,
    parameter int CNT_W       = 5
) (
    input  logic             clk,
    input  logic             reset,
    key_debounce_2b_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic [1:0]       sync_r [SYNC_STAGES];
    logic [1:0]       sync_q;
    state_t           state_q, state_d;
    logic [1:0]       cand_q, cand_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       out_q, out_d;

    assign sync_q           = sync_r[SYNC_STAGES-1];
    assign bus.state_inputs = out_q;

    // Multi-flop synchroniser for the raw key vector.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                sync_r[i] <= '0;
            end
        end else begin
            sync_r[0] <= bus.key_in;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sync_r[i] <= sync_r[i-1];
            end
        end
    end

    // State, candidate, counter and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cand_q  <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
        end
    end

    // Next-state and datapath decisions of the debounce FSM.
    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        case (state_q)
            S_IDLE: begin
                if (sync_q != out_q) begin
                    cand_d  = sync_q;
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (sync_q == cand_q) begin
                    if (cnt_q == CNT_LAST) begin
                        out_d   = cand_q;
                        state_d = S_COMMIT;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else if (sync_q == out_q) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cand_d = sync_q;
                    cnt_d  = '0;
                end
            end
            S_COMMIT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

`ifdef DB_CHANGE_STROBE_EN
    logic stb_q;

    assign bus.change_stb = stb_q;

    // Strobe is high exactly during the cycle spent in S_COMMIT.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stb_q <= 1'b0;
        end else begin
            stb_q <= (state_d == S_COMMIT);
        end
    end
`endif

endmodule

// File: tb/tb_key_debounce_2b.sv
// Testbench for key_debounce_2b: directed scenarios plus random key activity,
// checked against a run-length reference model.
module tb_key_debounce_2b;

    localparam int SS = 2;
    localparam int DB = 16;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    key_debounce_2b_if bus ();

    key_debounce_2b #(
        .SYNC_STAGES(SS),
        .DB_CYCLES  (DB),
        .CNT_W      (5)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: delay line of raw keys, current output, and the
    // length of the current run of identical synchronised values that
    // differ from the output.  A commit needs DB+1 such edges in a row and
    // is followed by one edge during which the input is ignored.
    logic [1:0] hist [$];
    logic [1:0] m_out;
    logic [1:0] run_val;
    int         run_len;
    bit         m_stb;

    function automatic void model_reset();
        hist.delete();
        for (int i = 0; i < SS; i++) hist.push_back(2'b00);
        m_out   = 2'b00;
        run_val = 2'b00;
        run_len = 0;
        m_stb   = 1'b0;
    endfunction

    function automatic void model_edge(input logic [1:0] k);
        logic [1:0] s;
        s = hist.pop_front();
        hist.push_back(k);
        if (m_stb) begin
            m_stb   = 1'b0;
            run_len = 0;
        end else if (s == m_out) begin
            run_len = 0;
        end else if (run_len > 0 && s == run_val) begin
            run_len++;
        end else begin
            run_val = s;
            run_len = 1;
        end
        if (run_len == DB + 1) begin
            m_out   = run_val;
            run_len = 0;
            m_stb   = 1'b1;
        end
    endfunction

    task automatic check_out(input string tag);
        checks++;
        assert (bus.state_inputs === m_out) else begin
            errors++;
            $error("FAIL %s state_inputs=%b expected=%b", tag, bus.state_inputs, m_out);
        end
`ifdef DB_CHANGE_STROBE_EN
        checks++;
        assert (bus.change_stb === m_stb) else begin
            errors++;
            $error("FAIL %s_stb change_stb=%b expected=%b", tag, bus.change_stb, m_stb);
        end
`endif
    endtask

    task automatic check_const(input string tag, input logic [1:0] exp);
        checks++;
        assert (bus.state_inputs === exp) else begin
            errors++;
            $error("FAIL %s state_inputs=%b expected=%b", tag, bus.state_inputs, exp);
        end
    endtask

    task automatic check_stb(input string tag, input logic exp);
`ifdef DB_CHANGE_STROBE_EN
        checks++;
        assert (bus.change_stb === exp) else begin
            errors++;
            $error("FAIL %s change_stb=%b expected=%b", tag, bus.change_stb, exp);
        end
`endif
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_edge(bus.key_in);
        #1;
        check_out(tag);
    endtask

    task automatic hold(input logic [1:0] k, input int n, input string tag);
        bus.key_in = k;
        repeat (n) tick(tag);
    endtask

    task automatic do_reset(input logic [1:0] k);
        @(negedge clk);
        reset      = 1'b0;
        bus.key_in = k;
        model_reset();
        #1;
        check_out("reset_hold");
        check_const("reset_clear", 2'b00);
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        // 1. Reset with keys held at 11, then full latency after release.
        bus.key_in = 2'b11;
        model_reset();
        #12;
        check_out("reset");
        check_const("reset_const", 2'b00);
        check_stb("reset_stb", 1'b0);
        reset = 1'b1;
        repeat (18) tick("t1_wait");
        check_const("t1_edge18", 2'b00);
        tick("t1_commit");
        check_const("t1_edge19", 2'b11);
        repeat (3) tick("t1_after");

        // 2. Clean step to 10 with a one-cycle strobe.
        do_reset(2'b10);
        repeat (18) tick("t2_wait");
        check_const("t2_edge18", 2'b00);
        tick("t2_commit");
        check_const("t2_edge19", 2'b10);
        check_stb("t2_stb_hi", 1'b1);
        tick("t2_after");
        check_stb("t2_stb_lo", 1'b0);

        // 3. Bouncing 00/01 every 3 clocks, then hold 01.
        do_reset(2'b00);
        for (int i = 0; i < 14; i++) hold((i % 2 == 0) ? 2'b01 : 2'b00, 3, "t3_bounce");
        check_const("t3_bounced", 2'b00);
        hold(2'b01, 18, "t3_wait");
        check_const("t3_edge18", 2'b00);
        tick("t3_commit");
        check_const("t3_edge19", 2'b01);

        // 4. Bounce-back: 11 briefly, then back to 00.
        do_reset(2'b00);
        hold(2'b11, 10, "t4_pulse");
        hold(2'b00, 30, "t4_back");
        check_const("t4_final", 2'b00);

        // 5. Candidate switch from 01 to 10.
        do_reset(2'b00);
        hold(2'b01, 8, "t5_first");
        hold(2'b10, 18, "t5_wait");
        check_const("t5_edge18", 2'b00);
        tick("t5_commit");
        check_const("t5_edge19", 2'b10);

        // 6. Reset in the middle of a pending debounce.
        do_reset(2'b00);
        hold(2'b11, 10, "t6_pending");
        do_reset(2'b11);
        repeat (18) tick("t6_wait");
        check_const("t6_edge18", 2'b00);
        tick("t6_commit");
        check_const("t6_edge19", 2'b11);

        // Random key activity with occasional resets.
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                do_reset(2'($urandom_range(0, 3)));
            end else begin
                hold(2'($urandom_range(0, 3)), int'($urandom_range(1, 24)), "random");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
